pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer feeding the decode/execute path.

---
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and single-outstanding instruction-fetch sequencer.
//   Holds the PC and issues one fetch at a time over the imem req/ack handshake.
//   It presents IR, PC and PC_plus_4 downstream over a valid/ready handshake, then
//   commits the next PC from the branch stage (NPC qualified by npc_valid).
//
// Parameters
//   RESET_PC     PC loaded on reset (word-aligned)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    leave IDLE and begin fetching at the current PC
//   halt                     after the next NPC commit, return to IDLE
//   NPC, npc_valid           next PC from the branch stage, 1-cycle pulse
//   imem_req, imem_addr      fetch request and address (address = PC)
//   imem_ack, imem_rdata     fetch completion and instruction word
//   IR, PC, PC_plus_4        registered instruction, its address, address + 4
//   ir_valid, ir_ready       downstream valid/ready handshake
//   misalign                 sticky flag: a committed NPC was not word-aligned
//   fetch_count, stall_count performance counters
//
// Configuration
//   FETCH_PERF_EN  when defined, fetch_count counts ISSUE handshakes and
//                  stall_count counts REQ cycles without imem_ack. When
//                  undefined, both ports are tied to zero.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] NPC,
  input  logic        npc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        misalign,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_WAIT_NPC,
    S_FAULT
  } state_t;

  state_t state;
  state_t state_next;
  state_t commit_target;

  logic handshake;
  logic commit;
  logic npc_misaligned;

  // The downstream handshake only counts while the instruction is being issued.
  // A PC commit happens either in WAIT_NPC or together with that handshake.
  assign handshake      = (state == S_ISSUE) && ir_valid && ir_ready;
  assign commit         = npc_valid && (handshake || (state == S_WAIT_NPC));
  assign npc_misaligned = (NPC[1:0] != 2'b00);

  // The request and address come straight from state and PC, so a reset
  // drops imem_req without waiting for a clock edge.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = PC;

  // Where the FSM goes once a PC commit happens: a misaligned target traps in
  // FAULT, otherwise halt decides between stopping and fetching again.
  always_comb begin
    commit_target = S_REQ;
    if (npc_misaligned) begin
      commit_target = S_FAULT;
    end else if (halt) begin
      commit_target = S_IDLE;
    end
  end

  // Next-state logic. FAULT is left only through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) state_next = npc_valid ? commit_target : S_WAIT_NPC;
      end
      S_WAIT_NPC: begin
        if (npc_valid) state_next = commit_target;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch datapath. IR and PC_plus_4 load together on the imem ack. They then
  // stay put until the next ack, so they are stable while the downstream stalls.
  // A misaligned NPC is still loaded into PC so it can be inspected after the trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC        <= RESET_PC;
      PC_plus_4 <= RESET_PC + 32'd4;
      IR        <= 32'h0;
      ir_valid  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      if ((state == S_REQ) && imem_ack) begin
        IR        <= imem_rdata;
        PC_plus_4 <= PC + 32'd4;
        ir_valid  <= 1'b1;
      end else if (handshake) begin
        ir_valid <= 1'b0;
      end
      if (commit) begin
        PC <= NPC;
        if (npc_misaligned) misalign <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running performance counters. They wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (handshake) fetch_count <= fetch_count + 32'd1;
      if ((state == S_REQ) && !imem_ack) stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Self-checking bench for pc_fetch_unit. A behavioural model tracks the fetch
//   sequence in terms of "fetch outstanding / instruction held / awaiting NPC /
//   trapped". A negedge compare process checks every DUT output against it.
//   Directed scenarios add literal expectations. A randomized phase follows.

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] NPC = 32'h0;
  logic        npc_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        misalign;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_pc4, m_ir, m_fcnt, m_scnt;
  logic        m_valid, m_fetching, m_await, m_faulted, m_misalign;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .NPC(NPC),
    .npc_valid(npc_valid), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IR(IR), .PC(PC),
    .PC_plus_4(PC_plus_4), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .misalign(misalign), .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Compare one value and record the result
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model returns to its post-reset condition
  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h4; m_ir = 32'h0;
    m_valid = 1'b0; m_fetching = 1'b0; m_await = 1'b0;
    m_faulted = 1'b0; m_misalign = 1'b0;
    m_fcnt = 32'h0; m_scnt = 32'h0;
  endtask

  // Advance the model by one clock, using the inputs presented before the edge
  task automatic model_step();
    logic commit;
    commit = 1'b0;
    if (!m_faulted) begin
      if (m_fetching) begin
        if (imem_ack) begin
          m_ir = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_fetching = 1'b0;
        end else begin
          m_scnt = m_scnt + 32'd1;
        end
      end else if (m_valid) begin
        if (ir_ready) begin
          m_valid = 1'b0; m_fcnt = m_fcnt + 32'd1;
          if (npc_valid) commit = 1'b1;
          else m_await = 1'b1;
        end
      end else if (m_await) begin
        if (npc_valid) begin
          commit = 1'b1; m_await = 1'b0;
        end
      end else if (start) begin
        m_fetching = 1'b1;
      end
    end
    if (commit) begin
      m_pc = NPC;
      if (NPC[1:0] != 2'b00) begin
        m_misalign = 1'b1; m_faulted = 1'b1;
      end else begin
        m_fetching = !halt;
      end
    end
  endtask

  // Present one cycle of inputs, clock it into DUT and model, and return just
  // after the following falling edge, where outputs are settled
  task automatic applyStimulus(input logic st, input logic hl, input logic [31:0] n,
                               input logic nv, input logic ak, input logic [31:0] rd,
                               input logic rdy);
    start = st; halt = hl; NPC = n; npc_valid = nv;
    imem_ack = ak; imem_rdata = rd; ir_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    start = 1'b0; halt = 1'b0; NPC = 32'h0; npc_valid = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [31:0] exp_f, exp_s;
    if (cmp_en) begin
`ifdef FETCH_PERF_EN
      exp_f = m_fcnt; exp_s = m_scnt;
`else
      exp_f = 32'h0; exp_s = 32'h0;
`endif
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_fetching});
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("IR", IR, m_ir);
      checkOutput("PC", PC, m_pc);
      checkOutput("PC_plus_4", PC_plus_4, m_pc4);
      checkOutput("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
      checkOutput("misalign", {31'b0, misalign}, {31'b0, m_misalign});
      checkOutput("fetch_count", fetch_count, exp_f);
      checkOutput("stall_count", stall_count, exp_s);
    end
  end

  initial begin
    logic [31:0] n;
    model_reset();
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    checkOutput("rst_PC", PC, 32'h0);
    checkOutput("rst_PC_plus_4", PC_plus_4, 32'h4);
    checkOutput("rst_IR", IR, 32'h0);
    checkOutput("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'h0);

    // Start, one-cycle ack with DEADBEEF
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_req", {31'b0, imem_req}, 32'h1);
    checkOutput("t1_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    checkOutput("t1_IR", IR, 32'hDEAD_BEEF);
    checkOutput("t1_PC", PC, 32'h0);
    checkOutput("t1_PC4", PC_plus_4, 32'h4);
    checkOutput("t1_valid", {31'b0, ir_valid}, 32'h1);

    // Handshake together with NPC=0x10: straight back to a request
    applyStimulus(0, 0, 32'h10, 1, 0, 0, 1);
    checkOutput("t2_req", {31'b0, imem_req}, 32'h1);
    checkOutput("t2_addr", imem_addr, 32'h10);
    applyStimulus(0, 0, 0, 0, 1, 32'h1111_0010, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t2_hold_IR", IR, 32'h1111_0010);
      checkOutput("t2_hold_PC", PC, 32'h10);
      checkOutput("t2_hold_valid", {31'b0, ir_valid}, 32'h1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t2_valid_drop", {31'b0, ir_valid}, 32'h0);
    checkOutput("t2_wait_noreq", {31'b0, imem_req}, 32'h0);

    // NPC=0x40 from WAIT_NPC, then four stall cycles
    applyStimulus(0, 0, 32'h40, 1, 0, 0, 0);
    checkOutput("t3_addr", imem_addr, 32'h40);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h4444_0040, 0);
`ifdef FETCH_PERF_EN
    checkOutput("t3_stall", stall_count, 32'd4);
    checkOutput("t3_fetch", fetch_count, 32'd2);
`else
    checkOutput("t3_stall", stall_count, 32'd0);
    checkOutput("t3_fetch", fetch_count, 32'd0);
`endif

    // npc_valid at the handshake skips WAIT_NPC
    applyStimulus(0, 0, 32'h20, 1, 0, 0, 1);
    checkOutput("t4_req", {31'b0, imem_req}, 32'h1);
    checkOutput("t4_addr", imem_addr, 32'h20);

    // Wrap at the top of the address space, then a misaligned commit
    applyStimulus(0, 0, 0, 0, 1, 32'h2222_0020, 0);
    applyStimulus(0, 0, 32'hFFFF_FFFC, 1, 0, 0, 1);
    checkOutput("t5_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1, 32'h5555_AAAA, 0);
    checkOutput("t5_PC4_wrap", PC_plus_4, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 32'h6, 1, 0, 0, 0);
    checkOutput("t5_misalign", {31'b0, misalign}, 32'h1);
    checkOutput("t5_PC", PC, 32'h6);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 1);
      checkOutput("t5_fault_noreq", {31'b0, imem_req}, 32'h0);
    end

    // halt: commit then back to idle, npc_valid while idle is ignored
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0BAD_F00D, 0);
    applyStimulus(0, 1, 32'h100, 1, 0, 0, 1);
    checkOutput("halt_noreq", {31'b0, imem_req}, 32'h0);
    checkOutput("halt_PC", PC, 32'h100);
    applyStimulus(0, 0, 32'h200, 1, 1, 0, 1);
    checkOutput("idle_npc_ignored", PC, 32'h100);

    // Reset mid-request, late ack afterwards
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    applyStimulus(0, 0, 32'h80, 1, 0, 0, 1);
    checkOutput("t6_req_before", {31'b0, imem_req}, 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("t6_req_async", {31'b0, imem_req}, 32'h0);
    checkOutput("t6_PC", PC, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
    checkOutput("t6_late_ack_req", {31'b0, imem_req}, 32'h0);
    checkOutput("t6_late_ack_IR", IR, 32'h0);
    checkOutput("t6_late_ack_valid", {31'b0, ir_valid}, 32'h0);

    // Randomized segments, each starting from reset
    for (int seg = 0; seg < 6; seg++) begin
      doReset();
      for (int c = 0; c < 300; c++) begin
        n = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 49) == 0) n[1:0] = 2'($urandom_range(1, 3));
        applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), n,
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                      $urandom, 1'($urandom_range(0, 1)));
      end
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
